// File: rtl/counter_seq.sv
// counter_seq: command sequencer (load/up/down/goto) driving a W-bit up/down counter.
// Define COUNTER_SEQ_GOTO_EN to build the GOTO path; otherwise op 11 retires with err.
module counter_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    input  logic         abort,
    output logic         ctr_ld,
    output logic [W-1:0] ctr_ld_val,
    output logic         ctr_dir,
    output logic         ctr_en,
    input  logic [W-1:0] ctr_count,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t       state;
    logic [W-1:0] rem;
    logic         run_en;
    logic         finish;
`ifdef COUNTER_SEQ_GOTO_EN
    logic         goto_mode;
    logic [W-1:0] target;
    logic [W-1:0] dist;
    assign dist   = cmd_arg - ctr_count;
    // GOTO enables stop combinationally the moment the counter reaches target
    assign run_en = goto_mode ? ctr_count != target : 1'b1;
    assign finish = goto_mode ? ctr_count == target : rem == W'(1);
`else
    assign run_en = 1'b1;
    assign finish = rem == W'(1);
`endif
    assign cmd_ready = rst && state == IDLE;
    assign busy      = state != IDLE;
    assign ctr_ld    = state == LOAD && !abort;
    assign ctr_en    = state == RUN && !abort && run_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rem        <= '0;
            ctr_ld_val <= '0;
            ctr_dir    <= 1'b1;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
`ifdef COUNTER_SEQ_GOTO_EN
            goto_mode  <= 1'b0;
            target     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
`ifdef COUNTER_SEQ_GOTO_EN
                    goto_mode <= cmd_op == 2'b11;
`endif
                    case (cmd_op)
                        2'b00: begin
                            ctr_ld_val <= cmd_arg;
                            state      <= LOAD;
                        end
                        2'b01, 2'b10: begin
                            ctr_dir <= !cmd_op[1];
                            rem     <= cmd_arg;
                            state   <= cmd_arg == '0 ? DONE : RUN;
                            done    <= cmd_arg == '0;
                        end
                        default: begin
`ifdef COUNTER_SEQ_GOTO_EN
                            // shortest modular path; an exact half-way tie goes up
                            target  <= cmd_arg;
                            ctr_dir <= dist <= {1'b1, {(W-1){1'b0}}};
                            state   <= RUN;
`else
                            err     <= 1'b1;
                            done    <= 1'b1;
                            state   <= DONE;
`endif
                        end
                    endcase
                end
                LOAD: begin
                    aborted <= abort;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                RUN: begin
                    rem <= rem - W'(1);
                    if (abort || finish) begin
                        aborted <= abort;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    aborted <= 1'b0;
                    err     <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: directed self-checking bench for counter_seq with a behavioural 4-bit counter.
module tb_counter_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_arg = 4'd0;
    logic       abort = 1'b0;
    logic       ctr_ld, ctr_dir, ctr_en;
    logic [3:0] ctr_ld_val;
    logic [3:0] count = 4'd0;
    logic       busy, done, aborted, err;
    int         tests = 0, fails = 0;
    int         en_cnt = 0, ld_cnt = 0, done_cnt = 0, lat = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ctr_ld) count <= ctr_ld_val;
        else if (ctr_en) count <= ctr_dir ? count + 4'd1 : count - 4'd1;

    counter_seq #(.W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .ctr_ld(ctr_ld),
        .ctr_ld_val(ctr_ld_val), .ctr_dir(ctr_dir), .ctr_en(ctr_en),
        .ctr_count(count), .busy(busy), .done(done), .aborted(aborted), .err(err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        en_cnt   += int'(ctr_en);
        ld_cnt   += int'(ctr_ld);
        done_cnt += int'(done);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] arg);
        chk("ready_before_issue", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        en_cnt    = 0;
        ld_cnt    = 0;
        done_cnt  = 0;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [3:0] arg,
                       input int exp_lat, input int exp_en, input int exp_count, input int exp_err);
        issue(op, arg);
        wait_done();
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_err"}, int'(err), exp_err);
        chk({tag, "_aborted"}, int'(aborted), 0);
        step();
        chk({tag, "_enables"}, en_cnt, exp_en);
        chk({tag, "_count"}, int'(count), exp_count);
        chk({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ld", int'(ctr_ld), 0);
        chk("rst_en", int'(ctr_en), 0);
        chk("rst_dir", int'(ctr_dir), 1);
        chk("rst_ld_val", int'(ctr_ld_val), 0);
        chk("rst_flags", int'({aborted, err}), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", int'(cmd_ready), 1);
        @(negedge clk);
        // LOAD 9
        issue(2'b00, 4'd9);
        chk("load_ld", int'(ctr_ld), 1);
        chk("load_ld_val", int'(ctr_ld_val), 9);
        chk("load_en", int'(ctr_en), 0);
        chk("load_busy", int'(busy), 1);
        wait_done();
        chk("load_latency", lat, 2);
        step();
        chk("load_count", int'(count), 9);
        chk("load_ld_cycles", ld_cnt, 1);
        chk("load_done_pulses", done_cnt, 1);
        // UP 3 from 9
        issue(2'b01, 4'd3);
        chk("up_dir", int'(ctr_dir), 1);
        chk("up_ld_val_held", int'(ctr_ld_val), 9);
        wait_done();
        chk("up_latency", lat, 4);
        step();
        chk("up_enables", en_cnt, 3);
        chk("up_count", int'(count), 12);
        chk("up_done_pulses", done_cnt, 1);
        // DOWN 5 from 2 wraps to 13
        run("load2", 2'b00, 4'd2, 2, 0, 2, 0);
        issue(2'b10, 4'd5);
        chk("down_dir", int'(ctr_dir), 0);
        wait_done();
        chk("down_latency", lat, 6);
        step();
        chk("down_enables", en_cnt, 5);
        chk("down_count", int'(count), 13);
        chk("down_dir_held_idle", int'(ctr_dir), 0);
        run("up0", 2'b01, 4'd0, 1, 0, 13, 0);
`ifdef COUNTER_SEQ_GOTO_EN
        run("load14", 2'b00, 4'd14, 2, 0, 14, 0);
        run("goto_14_1", 2'b11, 4'd1, 5, 3, 1, 0);
        run("load0", 2'b00, 4'd0, 2, 0, 0, 0);
        run("goto_tie", 2'b11, 4'd8, 10, 8, 8, 0);
        chk("goto_tie_dir", int'(ctr_dir), 1);
        run("goto_same", 2'b11, 4'd8, 2, 0, 8, 0);
        run("goto_down", 2'b11, 4'd5, 5, 3, 5, 0);
        chk("goto_down_dir", int'(ctr_dir), 0);
`else
        run("goto_off", 2'b11, 4'd5, 1, 0, 13, 1);
`endif
        // UP 10 from 0, abort in the 5th RUN cycle, next command held pending
        run("load0_abort", 2'b00, 4'd0, 2, 0, 0, 0);
        issue(2'b01, 4'd10);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_arg   = 4'd7;
        repeat (4) begin
            chk("run_not_ready", int'(cmd_ready), 0);
            step();
        end
        abort = 1'b1;
        #1;
        chk("abort_en", int'(ctr_en), 0);
        step();
        abort = 1'b0;
        chk("abort_done", int'(done), 1);
        chk("abort_flag", int'(aborted), 1);
        chk("abort_err", int'(err), 0);
        step();
        chk("abort_ready_idle", int'(cmd_ready), 1);
        chk("abort_enables", en_cnt, 4);
        chk("abort_count", int'(count), 4);
        chk("abort_ld_cycles", ld_cnt, 0);
        step();
        cmd_valid = 1'b0;
        chk("held_cmd_ld", int'(ctr_ld), 1);
        chk("held_cmd_ld_val", int'(ctr_ld_val), 7);
        wait_done();
        step();
        chk("held_cmd_count", int'(count), 7);
        // reset during DOWN 6
        issue(2'b10, 4'd6);
        step();
        step();
        chk("pre_rst_en", int'(ctr_en), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_en", int'(ctr_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(cmd_ready), 0);
        chk("async_rst_dir", int'(ctr_dir), 1);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        repeat (10) step();
        chk("rst_no_done", done_cnt, 0);
        chk("rst_count", int'(count), 5);
        chk("rst_ready_again", int'(cmd_ready), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/counter_seq.md
# counter_seq

Command sequencer for the 4-bit up/down counter datapath. It accepts one command at a time over a valid/ready handshake: load, count up N, count down N, or go to a target value. It drives the counter's `ld`/`ld_val`/`dir`/`en` inputs, watches its `count` output, and pulses `done` when the command retires. It sits between a host or test controller and the counter instance, and is the only agent driving the counter's control pins.

## Interface
- `W`, 4, counter width; must match the counter's `count` width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE.
- `cmd_op`  in  2  00 LOAD, 01 UP, 10 DOWN, 11 GOTO.
- `cmd_arg`  in  W  meaning by op: LOAD value, UP/DOWN step count, or GOTO target.
- `abort`  in  1  terminates the command in flight.
- `ctr_ld`  out  1  to counter `ld`.
- `ctr_ld_val`  out  W  to counter `ld_val`.
- `ctr_dir`  out  1  to counter `dir` (1 = up).
- `ctr_en`  out  1  to counter `en`.
- `ctr_count`  in  W  from counter `count`.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle retire pulse.
- `aborted`  out  1  qualifies `done`: the command was aborted.
- `err`  out  1  qualifies `done`: illegal op.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Acceptance: a command is accepted on the edge where `cmd_valid && cmd_ready`. The op and arg are latched. Inputs are ignored outside IDLE.
- LOAD:
  - One cycle with `ctr_ld=1`, `ctr_ld_val=arg`, `ctr_en=0`.
  - Then DONE.
- UP/DOWN:
  - RUN for exactly `arg` cycles with `ctr_en=1`. `ctr_dir` is 1 for UP and 0 for DOWN, held constant.
  - A W-bit remaining counter decrements each cycle.
  - `arg=0` goes IDLE→DONE directly with no enable cycles.
- GOTO:
  - In RUN, `ctr_en = (ctr_count != target)` combinationally.
  - Direction is latched at entry as the shortest modular path: up if `(target - count) mod 2^W <= 2^(W-1)`, else down. An exact tie goes up.
  - Leaves RUN for DONE in the cycle where `ctr_count == target`, with `ctr_en=0` that cycle.
  - Target equal to current count: one RUN cycle, zero enables.
- Wrap-around: the counter wraps modulo 2^W. The sequencer does no saturation.
- Abort:
  - In LOAD or RUN, `abort=1` forces `ctr_en=0` and `ctr_ld=0` that cycle and moves to DONE with `aborted=1`.
  - An enable issued before the abort cycle is not undone.
  - Abort in IDLE or DONE is ignored.
- DONE: one cycle with `done=1` and flags valid, then IDLE.
- Outputs in IDLE/DONE: `ctr_ld=0`, `ctr_en=0`. `ctr_dir` and `ctr_ld_val` hold their last value.

## Timing
- Reset values: state IDLE, `cmd_ready=1` (after reset releases; 0 while `rst=0`), `busy=0`, `done=0`, `aborted=0`, `err=0`, `ctr_ld=0`, `ctr_ld_val=0`, `ctr_dir=1`, `ctr_en=0`.
- Reset mid-command: all counter controls drop to 0 immediately (asynchronous). The command is lost and no `done` is issued.
- Accept at edge T:
  - LOAD: `ctr_ld` in cycle T+1, `done` in T+2.
  - UP/DOWN N: `ctr_en` in cycles T+1..T+N, `done` in T+N+1. For N=0, `done` in T+1.
  - GOTO at distance D: `done` in T+D+2.
- Next command: earliest acceptance is the edge after the `done` cycle. There is no back-to-back overlap.
- `done`, `aborted`, `err` are registered. `ctr_en` in GOTO is combinational from `ctr_count`.

## Configuration
- `COUNTER_SEQ_GOTO_EN`
  - Defined: GOTO is supported as described.
  - Undefined: the GOTO logic is removed. Op 11 is accepted, causes no counter activity, and goes IDLE→DONE with `err=1`.

## Test plan
- Reset, LOAD 9 → `ctr_ld` high one cycle with `ctr_ld_val=9`, `done` the following cycle, `ctr_count=9`.
- From 9, UP 3 → `ctr_en` high for exactly 3 cycles with `ctr_dir=1`, count 12, one `done`. Then DOWN 5 from 2 → count wraps to 13.
- UP 0 → `done` one cycle after accept, zero enables, count unchanged.
- GOTO (macro defined):
  - From 14 to 1 → up path, 3 enables, count 1.
  - From 0 to 8 → tie, goes up, 8 enables.
  - Macro undefined: op 11 → `done` with `err=1`, count unchanged.
- UP 10 from 0 with `abort` in the 5th RUN cycle → count 4, `done` with `aborted=1`. `cmd_valid` held during RUN is not accepted until IDLE.
- `rst` low during DOWN 6 → `ctr_en=0` without waiting for an edge, `busy=0`, no `done` after release.
